sensor_scheduler: RTL and testbench

- Sequences up to N_SENSORS measurement blocks and the shared byte-wide UART transmitter.
- Each period it walks the enabled sensors in ascending index order. For each one it starts a measurement, captures the 16-bit result, and sends a 4-byte frame over the transmitter.
- Sits between the top-level LED/debug logic and the sensor/UART instances, replacing the ad-hoc top-level FSM.

---
 rtl/sensor_scheduler_pkg.sv | 40 ++++
 rtl/sensor_scheduler_next_set_index.sv | 26 ++
 rtl/sensor_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_sensor_scheduler.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_scheduler_pkg.sv
// Shared types and constants for the sensor round scheduler.
// State encodings, frame layout and the frame byte mux.
package sensor_scheduler_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_WAIT_BUSY = 4'd2,
    S_WAIT_DONE = 4'd3,
    S_TX_LOAD   = 4'd4,
    S_TX_ACK    = 4'd5,
    S_TX_DONE   = 4'd6,
    S_NEXT      = 4'd7
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [1:0] BYTE_SYNC = 2'd0;
  localparam logic [1:0] BYTE_HDR  = 2'd1;
  localparam logic [1:0] BYTE_HI   = 2'd2;
  localparam logic [1:0] BYTE_LO   = 2'd3;

  function automatic logic [7:0] frame_byte(
    input logic [1:0]  k,
    input logic [7:0]  sync,
    input logic        to,
    input logic [3:0]  idx,
    input logic [15:0] data
  );
    logic [7:0] b;
    case (k)
      BYTE_SYNC: b = sync;
      BYTE_HDR:  b = {3'b000, to, idx};
      BYTE_HI:   b = data[15:8];
      default:   b = data[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sensor_scheduler_next_set_index.sv
// Priority encoder: lowest set mask bit above (or at) a base index.
// Inclusive mode finds the first sensor of a round.
module sensor_scheduler_next_set_index #(
  parameter int N = 4
) (
  input  logic [N-1:0] mask,
  input  logic [3:0]   base,
  input  logic         inclusive,
  output logic [3:0]   idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] &&
          ((i > int'(base)) ||
           (inclusive && i == int'(base)))) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_scheduler.sv
// Periodic round scheduler: starts each enabled sensor in turn
// and ships its 16-bit result as a 4-byte frame over the UART.
module sensor_scheduler
  import sensor_scheduler_pkg::*;
#(
  parameter int         N_SENSORS      = 4,
  parameter int         PERIOD_CYCLES  = 50_000_000,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_SENSORS-1:0]    sensor_mask,
  output logic [N_SENSORS-1:0]    sensor_initiate,
  input  logic [N_SENSORS-1:0]    sensor_ready,
  input  logic [16*N_SENSORS-1:0] sensor_data,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic [3:0]              cur_sensor,
  output logic                    overrun,
  output logic                    timeout_flag
);

  localparam int PW =
    (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] PERIOD_LAST =
    PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [PW-1:0]          per_q, per_d;
  logic [TW-1:0]          wait_q, wait_d;
  logic [N_SENSORS-1:0]   mask_q, mask_d;
  logic [3:0]             cur_q, cur_d;
  logic [1:0]             k_q, k_d;
  logic [15:0]            data_q, data_d;
  logic                   to_q, to_d;
  logic [N_SENSORS-1:0]   init_q, init_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   tflag_q, tflag_d;

  logic                   tick;
  logic                   wait_hit;
  logic [15:0]            rdy_pad;
  logic [255:0]           data_pad;
  logic                   rdy_cur;
  logic [15:0]            data_cur;
  logic [N_SENSORS-1:0]   enc_mask;
  logic [3:0]             enc_base;
  logic                   enc_incl;
  logic [3:0]             nxt_idx;
  logic                   nxt_valid;

  // Pad to 16 slots so a 4-bit index is always in range.
  assign rdy_pad  = 16'(sensor_ready);
  assign data_pad = 256'(sensor_data);
  assign rdy_cur  = rdy_pad[cur_q];
  assign data_cur = data_pad[{cur_q, 4'b0000} +: 16];

  assign tick     = (per_q == PERIOD_LAST);
  assign wait_hit = (wait_q == TIMEOUT_LAST);

  assign enc_incl = (state_q == S_IDLE);
  assign enc_mask = enc_incl ? sensor_mask : mask_q;
  assign enc_base = enc_incl ? 4'd0 : cur_q;

  sensor_scheduler_next_set_index #(
    .N (N_SENSORS)
  ) u_next (
    .mask      (enc_mask),
    .base      (enc_base),
    .inclusive (enc_incl),
    .idx       (nxt_idx),
    .valid     (nxt_valid)
  );

  always_comb begin
    state_d    = state_q;
    per_d      = tick ? '0 : per_q + PW'(1);
    mask_d     = mask_q;
    cur_d      = cur_q;
    k_d        = k_q;
    data_d     = data_q;
    to_d       = to_q;
    init_d     = '0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    overrun_d  = tick && busy_q;
    tflag_d    = tflag_q;

    unique case (state_q)
      S_IDLE: begin
        if (tick && enable && nxt_valid) begin
          mask_d  = sensor_mask;
          cur_d   = nxt_idx;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START, S_WAIT_BUSY, S_WAIT_DONE: begin
        if (state_q == S_START && rdy_cur) begin
          init_d  = N_SENSORS'(16'd1 << cur_q);
          state_d = S_WAIT_BUSY;
        end else if (state_q == S_WAIT_BUSY && !rdy_cur) begin
          state_d = S_WAIT_DONE;
        end else if (state_q == S_WAIT_DONE && rdy_cur) begin
          data_d  = data_cur;
          to_d    = 1'b0;
          k_d     = BYTE_SYNC;
          state_d = S_TX_LOAD;
        end else if (wait_hit) begin
          // A dead sensor still gets a frame, flagged and zeroed.
          data_d  = '0;
          to_d    = 1'b1;
          tflag_d = 1'b1;
          k_d     = BYTE_SYNC;
          state_d = S_TX_LOAD;
        end
      end
      S_TX_LOAD: begin
        if (tx_ready) begin
          tx_data_d  = frame_byte(k_q, SYNC_BYTE, to_q,
                                  cur_q, data_q);
          tx_start_d = 1'b1;
          state_d    = S_TX_ACK;
        end else if (wait_hit) begin
          tflag_d = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_TX_ACK: begin
        if (!tx_ready) begin
          state_d = S_TX_DONE;
        end else if (wait_hit) begin
          tflag_d = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_TX_DONE: begin
        if (tx_ready) begin
          if (k_q != BYTE_LO) begin
            k_d     = k_q + 2'd1;
            state_d = S_TX_LOAD;
          end else begin
            state_d = S_NEXT;
          end
        end else if (wait_hit) begin
          tflag_d = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (nxt_valid) begin
          cur_d   = nxt_idx;
          state_d = S_START;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign wait_d = (state_d != state_q) ? '0 : wait_q + TW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      per_q      <= '0;
      wait_q     <= '0;
      mask_q     <= '0;
      cur_q      <= '0;
      k_q        <= '0;
      data_q     <= '0;
      to_q       <= 1'b0;
      init_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      tflag_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_q      <= per_d;
      wait_q     <= wait_d;
      mask_q     <= mask_d;
      cur_q      <= cur_d;
      k_q        <= k_d;
      data_q     <= data_d;
      to_q       <= to_d;
      init_q     <= init_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      tflag_q    <= tflag_d;
    end
  end

  assign sensor_initiate = init_q;
  assign tx_data         = tx_data_q;
  assign tx_start        = tx_start_q;
  assign busy            = busy_q;
  assign cur_sensor      = cur_q;
  assign overrun         = overrun_q;
  assign timeout_flag    = tflag_q;

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed bench for sensor_scheduler with behavioural
// sensors and a behavioural UART transmitter.
module tb_sensor_scheduler;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [N-1:0]   sensor_mask = '0;
  logic [N-1:0]   sensor_initiate;
  logic [N-1:0]   sensor_ready;
  logic [16*N-1:0] sensor_data;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_ready;
  logic           busy;
  logic [3:0]     cur_sensor;
  logic           overrun;
  logic           timeout_flag;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  int         init_cnt[N];
  int         ov_cnt;
  int         scnt[N];
  logic [N-1:0] srdy;
  logic       stuck0 = 1'b0;
  int         uart_low = 50;
  int         ucnt;
  logic       urdy;

  always #5 clk = ~clk;

  assign sensor_data  = {16'hABCD, 16'h1234};
  assign sensor_ready = srdy;
  assign tx_ready     = urdy;

  sensor_scheduler #(
    .N_SENSORS      (N),
    .PERIOD_CYCLES  (1000),
    .TIMEOUT_CYCLES (3000),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .sensor_mask     (sensor_mask),
    .sensor_initiate (sensor_initiate),
    .sensor_ready    (sensor_ready),
    .sensor_data     (sensor_data),
    .tx_data         (tx_data),
    .tx_start        (tx_start),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .cur_sensor      (cur_sensor),
    .overrun         (overrun),
    .timeout_flag    (timeout_flag)
  );

  // Sensors: busy for 20 cycles after a start pulse.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        srdy[i] <= 1'b1;
        scnt[i] <= 0;
      end else if (sensor_initiate[i] &&
                   !(i == 0 && stuck0)) begin
        srdy[i] <= 1'b0;
        scnt[i] <= 20;
      end else if (scnt[i] > 0) begin
        scnt[i] <= scnt[i] - 1;
        if (scnt[i] == 1) srdy[i] <= 1'b1;
      end
    end
  end

  // UART: busy for uart_low cycles after tx_start.
  always @(negedge clk) begin
    if (reset) begin
      urdy <= 1'b1;
      ucnt <= 0;
    end else if (tx_start) begin
      urdy <= 1'b0;
      ucnt <= uart_low;
    end else if (ucnt > 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) urdy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      for (int i = 0; i < N; i++) init_cnt[i] = 0;
      ov_cnt = 0;
    end else begin
      if (tx_start) q.push_back(tx_data);
      for (int i = 0; i < N; i++)
        if (sensor_initiate[i]) init_cnt[i]++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if (sensor_initiate !== '0) begin
      bad++;
      $display("FAIL rst_init got=%b want=00", sensor_initiate);
    end
    total++;
    if (tx_data !== 8'h00) begin
      bad++;
      $display("FAIL rst_txdata got=%h want=00", tx_data);
    end
    total++;
    if (tx_start !== 1'b0) begin
      bad++;
      $display("FAIL rst_txstart got=%b want=0", tx_start);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got=%b want=0", busy);
    end
    total++;
    if (cur_sensor !== 4'd0) begin
      bad++;
      $display("FAIL rst_cur got=%0d want=0", cur_sensor);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL rst_overrun got=%b want=0", overrun);
    end
    total++;
    if (timeout_flag !== 1'b0) begin
      bad++;
      $display("FAIL rst_tflag got=%b want=0", timeout_flag);
    end
  endtask

  task automatic test_two_sensors();
    logic [7:0] exp [8];
    logic [7:0] got;
    exp = '{8'hA5, 8'h00, 8'h12, 8'h34,
            8'hA5, 8'h01, 8'hAB, 8'hCD};
    do_reset();
    sensor_mask = 2'b11;
    enable = 1'b1;
    cycles(1900);
    total++;
    if (q.size() != 8) begin
      bad++;
      $display("FAIL t1_count got=%0d want=8", q.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL t1_byte%0d got=%h want=%h",
                 i, got, exp[i]);
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL t1_busy got=%b want=0", busy);
    end
    total++;
    if (init_cnt[0] != 1 || init_cnt[1] != 1) begin
      bad++;
      $display("FAIL t1_init got=%0d,%0d want=1,1",
               init_cnt[0], init_cnt[1]);
    end
    total++;
    if (timeout_flag !== 1'b0 || ov_cnt != 0) begin
      bad++;
      $display("FAIL t1_flags got=tf%b ov%0d want=tf0 ov0",
               timeout_flag, ov_cnt);
    end
    enable = 1'b0;
  endtask

  task automatic test_mask_one();
    logic [7:0] exp [4];
    logic [7:0] got;
    exp = '{8'hA5, 8'h01, 8'hAB, 8'hCD};
    do_reset();
    sensor_mask = 2'b10;
    enable = 1'b1;
    cycles(1900);
    total++;
    if (q.size() != 4) begin
      bad++;
      $display("FAIL t2_count got=%0d want=4", q.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL t2_byte%0d got=%h want=%h",
                 i, got, exp[i]);
      end
    end
    total++;
    if (init_cnt[0] != 0 || init_cnt[1] != 1) begin
      bad++;
      $display("FAIL t2_init got=%0d,%0d want=0,1",
               init_cnt[0], init_cnt[1]);
    end
    enable = 1'b0;
  endtask

  task automatic test_timeout();
    logic [7:0] exp [8];
    logic [7:0] got;
    exp = '{8'hA5, 8'h10, 8'h00, 8'h00,
            8'hA5, 8'h01, 8'hAB, 8'hCD};
    do_reset();
    stuck0 = 1'b1;
    sensor_mask = 2'b11;
    enable = 1'b1;
    cycles(4900);
    total++;
    if (q.size() != 8) begin
      bad++;
      $display("FAIL t3_count got=%0d want=8", q.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL t3_byte%0d got=%h want=%h",
                 i, got, exp[i]);
      end
    end
    total++;
    if (timeout_flag !== 1'b1) begin
      bad++;
      $display("FAIL t3_tflag got=%b want=1", timeout_flag);
    end
    enable = 1'b0;
    stuck0 = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] exp [8];
    logic [7:0] got;
    exp = '{8'hA5, 8'h00, 8'h12, 8'h34,
            8'hA5, 8'h01, 8'hAB, 8'hCD};
    do_reset();
    cycles(1);
    total++;
    if (timeout_flag !== 1'b0) begin
      bad++;
      $display("FAIL t4_tflag_clr got=%b want=0",
               timeout_flag);
    end
    uart_low = 2000;
    sensor_mask = 2'b11;
    enable = 1'b1;
    cycles(17500);
    // Round spans ticks 2000..17000 after release.
    total++;
    if (ov_cnt != 16) begin
      bad++;
      $display("FAIL t4_overruns got=%0d want=16", ov_cnt);
    end
    total++;
    if (q.size() != 8) begin
      bad++;
      $display("FAIL t4_count got=%0d want=8", q.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL t4_byte%0d got=%h want=%h",
                 i, got, exp[i]);
      end
    end
    enable = 1'b0;
    uart_low = 50;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [8];
    logic [7:0] got;
    bit found;
    exp = '{8'hA5, 8'h00, 8'h12, 8'h34,
            8'hA5, 8'h01, 8'hAB, 8'hCD};
    do_reset();
    sensor_mask = 2'b11;
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1 && tx_data === 8'h12)
        found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL t5_reach_byte2 got=timeout want=seen");
    end
    reset = 1'b1;
    #1;
    total++;
    if ({sensor_initiate, tx_data, tx_start, busy,
         cur_sensor, overrun, timeout_flag} !== '0) begin
      bad++;
      $display("FAIL t5_async got=%b/%h/%b/%b/%0d/%b/%b want=0",
               sensor_initiate, tx_data, tx_start, busy,
               cur_sensor, overrun, timeout_flag);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cycles(1900);
    total++;
    if (q.size() != 8) begin
      bad++;
      $display("FAIL t5_count got=%0d want=8", q.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL t5_byte%0d got=%h want=%h",
                 i, got, exp[i]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_idle();
    do_reset();
    sensor_mask = 2'b00;
    enable = 1'b1;
    cycles(3100);
    total++;
    if (q.size() != 0 || init_cnt[0] != 0 ||
        init_cnt[1] != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t6_mask0 got=tx%0d i%0d,%0d b%b want=0",
               q.size(), init_cnt[0], init_cnt[1], busy);
    end
    do_reset();
    sensor_mask = 2'b11;
    enable = 1'b0;
    cycles(3100);
    total++;
    if (q.size() != 0 || init_cnt[0] != 0 ||
        init_cnt[1] != 0 || ov_cnt != 0) begin
      bad++;
      $display("FAIL t6_disabled got=tx%0d i%0d,%0d ov%0d want=0",
               q.size(), init_cnt[0], init_cnt[1], ov_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_two_sensors();
    test_mask_one();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
